apb_slave_regbank: RTL and testbench

//  APB slave register bank; consumes the APB side of the AHB-to-APB bridge (paddr/psel/penable/pwdata in, prdata/pready out).

---
 rtl/apb_slv_pkg.sv | 10 +
 rtl/apb_slv_decode.sv | 22 ++
 rtl/apb_slave_regbank.sv | 102 ++++++++++
 tb/tb_apb_slave_regbank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types and constants for the APB slave register bank
package apb_slv_pkg;
  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
  localparam logic [31:0] ID_VALUE = 32'hA2B0_0001;
  localparam int ID_IDX = 0;
  localparam int WAIT_W = 4;
  function automatic int wait_idx(input int reg_num);
    return reg_num - 1;
  endfunction
endpackage

// File: rtl/apb_slv_decode.sv
// apb_slv_decode: byte address to word index plus illegal-access flag
module apb_slv_decode
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_NUM = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
)(
  input  logic [ADDR_WIDTH-1:0]      paddr_i,
  input  logic                       pwrite_i,
  output logic [$clog2(REG_NUM)-1:0] idx_o,
  output logic                       err_o
);
  localparam int IW = $clog2(REG_NUM);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(REG_NUM * 4);
  logic [ADDR_WIDTH-1:0] w_offset;
  assign w_offset = paddr_i - BASE_ADDR;
  assign idx_o = w_offset[IW+1:2];
  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range
  assign err_o = (w_offset >= SPAN) || (paddr_i[1:0] != 2'b00) ||
                 (pwrite_i && idx_o == IW'(ID_IDX));
endmodule

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB word register file with byte strobes, RO ID word and PSLVERR.
// Define APB_SLV_WAIT_EN to make the top word a programmable wait-state count.
module apb_slave_regbank
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o
);
  localparam int IW = $clog2(REG_NUM);
  localparam int SW = DATA_WIDTH / 8;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic                  r_perr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_strb;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_regs [REG_NUM];
  logic [IW-1:0]         w_idx;
  logic                  w_err;
  logic                  w_ready;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_smask;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic [DATA_WIDTH-1:0] w_rword;
  logic [WAIT_W-1:0]     w_wait_load;

  apb_slv_decode #(.ADDR_WIDTH(ADDR_WIDTH), .REG_NUM(REG_NUM), .BASE_ADDR(BASE_ADDR)) u_decode (
    .paddr_i (r_addr),
    .pwrite_i(r_write),
    .idx_o   (w_idx),
    .err_o   (w_err)
  );

  for (genvar b = 0; b < SW; b++) begin : g_strb
    assign w_smask[8*b +: 8] = {8{r_strb[b]}};
  end

`ifdef APB_SLV_WAIT_EN
  localparam int WAIT_IDX = wait_idx(REG_NUM);
  assign w_wmask = (w_idx == IW'(WAIT_IDX)) ? (w_smask & DATA_WIDTH'({WAIT_W{1'b1}})) : w_smask;
  assign w_wait_load = r_regs[WAIT_IDX][WAIT_W-1:0];
`else
  assign w_wmask = w_smask;
  assign w_wait_load = '0;
`endif

  // A protocol-violation response is a one-cycle pulse issued from idle
  assign w_ready = (r_state == ST_ACCESS && r_wait_cnt == '0) || r_perr;
  assign w_done = r_state == ST_ACCESS && psel_i && penable_i && w_ready;
  assign w_rword = (w_idx == IW'(ID_IDX)) ? DATA_WIDTH'(ID_VALUE) : r_regs[w_idx];
  assign pready_o = w_ready;
  assign pslverr_o = w_ready && (r_perr || w_err);
  assign prdata_o = (w_ready && !r_perr && !w_err && !r_write) ? w_rword : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_addr <= '0;
      r_write <= 1'b0;
      r_perr <= 1'b0;
      r_wdata <= '0;
      r_strb <= '0;
      r_wait_cnt <= '0;
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else begin
      r_perr <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (psel_i && !penable_i) begin
          r_state <= ST_ACCESS;
          r_addr <= paddr_i;
          r_write <= pwrite_i;
          r_wdata <= pwdata_i;
          r_strb <= pstrb_i;
          r_wait_cnt <= w_wait_load;
        end else if (psel_i && penable_i) begin
          r_perr <= 1'b1;
        end
      end else if (!psel_i || w_done) begin
        r_state <= ST_IDLE;
      end else if (r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (w_done && r_write && !w_err)
        r_regs[w_idx] <= (r_regs[w_idx] & ~w_wmask) | (r_wdata & w_wmask);
    end
  end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: directed vector table plus hand sequences for abort, reset and protocol errors
module tb_apb_slave_regbank;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  int          checks = 0;
  int          fails = 0;

`ifdef APB_SLV_WAIT_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 0;
`endif

  apb_slave_regbank dut (
    .clk      (clk),
    .reset    (reset),
    .paddr_i  (paddr),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .pwdata_i (pwdata),
    .pstrb_i  (pstrb),
    .prdata_o (prdata),
    .pready_o (pready),
    .pslverr_o(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int lat);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    while (!pready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!pready) begin
      fails++;
      checks++;
      $display("FAIL timeout: pready never rose for addr %h", addr);
    end
    rdata = prdata;
    err = pslverr;
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp,
                    input logic exp_err, input int exp_lat);
    logic [31:0] d;
    logic        e;
    int          l;
    xfer(1'b0, addr, '0, '0, d, e, l);
    chk({name, " rdata"}, d, exp);
    chk({name, " err"}, 32'(e), 32'(exp_err));
    chk({name, " lat"}, 32'(l), 32'(exp_lat));
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic exp_err, input int exp_lat);
    logic [31:0] d;
    logic        e;
    int          l;
    xfer(1'b1, addr, data, strb, d, e, l);
    chk({name, " err"}, 32'(e), 32'(exp_err));
    chk({name, " lat"}, 32'(l), 32'(exp_lat));
  endtask

  vec_t vecs [17];

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA2B0_0001, 1'b0, 1};
    vecs[1]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'h5, 32'h0,         1'b0, 1};
    vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h00AD_00EF, 1'b0, 1};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 32'h0,         1'b1, 1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA2B0_0001, 1'b0, 1};
    vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h0,         1'b1, 1};
    vecs[6]  = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 32'h0,         1'b1, 1};
    vecs[7]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0,         1'b0, 1};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0,         1'b0, 1};
    vecs[9]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 1};
    vecs[10] = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'h8, 32'h0,         1'b0, 1};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h00FE_F00D, 1'b0, 1};
    vecs[12] = '{1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, 1};
    vecs[13] = '{1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, 1};
    vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, 1};
    vecs[15] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hA, 32'h0,         1'b0, 1};
    vecs[16] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hFFAD_FFEF, 1'b0, 1};

    repeat (3) @(negedge clk);
    chk("reset pready", 32'(pready), 32'h0);
    chk("reset pslverr", 32'(pslverr), 32'h0);
    chk("reset prdata", prdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle pready", 32'(pready), 32'h0);

    for (int i = 0; i < 17; i++) begin
      logic [31:0] d;
      logic        e;
      int          l;
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, d, e, l);
      if (!vecs[i].wr) chk($sformatf("vec%0d rdata", i), d, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d lat", i), 32'(l), 32'(vecs[i].exp_lat));
    end
    idle();

    // back-to-back write then read with no idle cycle
    wr("b2b wr", 32'h0000_000C, 32'h5, 4'hF, 1'b0, 1);
    rd("b2b rd", 32'h0000_000C, 32'h5, 1'b0, 1);
    idle();

    // penable without a preceding setup phase
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; paddr = 32'h0000_000C; pwrite = 1'b1; pwdata = 32'h77; pstrb = 4'hF;
    @(negedge clk);
    chk("perr pready", 32'(pready), 32'h1);
    chk("perr pslverr", 32'(pslverr), 32'h1);
    chk("perr prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("perr after pready", 32'(pready), 32'h0);
    rd("perr no effect", 32'h0000_000C, 32'h5, 1'b0, 1);
    idle();

`ifdef APB_SLV_WAIT_EN
    wr("wait cfg", 32'h0000_003C, 32'hFFFF_FFF3, 4'hF, 1'b0, 1);
    rd("wait rd", 32'h0000_0004, 32'hFFAD_FFEF, 1'b0, 4);
    rd("wait cfg rd", 32'h0000_003C, 32'h3, 1'b0, 4);
    idle();
`else
    wr("top word wr", 32'h0000_003C, 32'hFFFF_FFF3, 4'hF, 1'b0, 1);
    rd("top word rd", 32'h0000_003C, 32'hFFFF_FFF3, 1'b0, 1);
    idle();
`endif

    // abort: psel dropped before completion
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0008; pwdata = 32'd1234; pstrb = 4'hF;
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clk);
      penable = 1'b1;
      chk("abort wait pready", 32'(pready), 32'h0);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort pready", 32'(pready), 32'h0);
    rd("abort rd", 32'h0000_0008, 32'h0, 1'b0, HOLD ? 4 : 1);
    idle();

    // asynchronous reset in the middle of a write
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0014; pwdata = 32'hAAAA_5555; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst pready", 32'(pready), 32'h0);
    chk("midrst prdata", prdata, 32'h0);
    @(negedge clk);
    reset = 1'b1; psel = 1'b0; penable = 1'b0;
    rd("midrst word14", 32'h0000_0014, 32'h0, 1'b0, 1);
    rd("midrst word4", 32'h0000_0004, 32'h0, 1'b0, 1);
    rd("midrst wordC", 32'h0000_000C, 32'h0, 1'b0, 1);
    rd("midrst word3C", 32'h0000_003C, 32'h0, 1'b0, 1);
    rd("midrst id", 32'h0000_0000, 32'hA2B0_0001, 1'b0, 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
